// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types for the nibble-serial subtractor: FSM state encoding and slice width.
// No logic, so no latency.
// No handshake, so no backpressure.
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// No logic, so no latency.
// Valid/ready on both sides. The master drives operands and out_ready; the slave (the subtractor) drives the rest.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );

endinterface

// File: rtl/nibble_serial_subtractor_cla4_slice.sv
// 4-bit carry-lookahead adder slice. The caller supplies inverted b and c_in=1 to subtract.
// Purely combinational, so no latency.
// No handshake, so no backpressure.
module nibble_serial_subtractor_cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from g/p and c_in so that no carry waits on the previous bit.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
  end

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor (a - b). It handles one nibble per clock, starting at the LSB, through a single CLA slice.
// Result valid WIDTH/4 edges after the accept edge. Throughput is one operation per WIDTH/4+2 cycles.
// in_ready is low from accept until the result is taken. The result and flags are held while out_ready is low.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  nibble_serial_subtractor_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   nb_q;
  logic [WIDTH-1:0]   shadow_q;
  logic [WIDTH-1:0]   full_diff;

  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;
  logic               ovf_q;
  logic               zero_q;

  logic               accept;
  logic               step;
  logic               finish;
  logic               last;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_nb;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_cout;

  assign last   = (idx_q == LAST_IDX);
  assign nib_a  = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_nb = nb_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_serial_subtractor_cla4_slice u_slice (
    .a     (nib_a),
    .b     (nib_nb),
    .c_in  (carry_q),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  // The current nibble is merged into the shadow, so the completion edge sees the whole result at once.
  always_comb begin
    full_diff = shadow_q;
    full_diff[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
  end

  // State register. An async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus the per-cycle datapath strobes. Illegal encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands, carry chain, shadow result, registered outputs and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      nb_q        <= '0;
      shadow_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      if (accept) begin
        a_q     <= bus.a;
        nb_q    <= ~bus.b;
        carry_q <= 1'b1;
        idx_q   <= '0;
      end
      if (step) begin
        shadow_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_sum;
        carry_q <= nib_cout;
        if (!last) idx_q <= idx_q + 1'b1;
      end
      if (finish) begin
        diff_q   <= full_diff;
        borrow_q <= ~nib_cout;
        // The sign of b is the complement of nb_q's MSB, so "a and b differ in sign" becomes "a equals nb".
        ovf_q    <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (full_diff[WIDTH-1] != a_q[WIDTH-1]);
        zero_q   <= ~|full_diff;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor at WIDTH=16: a vector table plus sequences for reset, stall and abort.
// Expected results are hand-computed constants.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_nibble_serial_subtractor;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[8];

  nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents the operands for one accept edge, then scrambles a/b and counts edges until out_valid.
  task automatic start_op(input string tag, input logic [15:0] va, input logic [15:0] vb);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("%s in_ready", tag), bus.in_ready, 1);
    bus.a = va;
    bus.b = vb;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~va;
    bus.b = vb ^ 16'h5555;
    check($sformatf("%s busy", tag), bus.in_ready, 0);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("%s latency", tag), n, 4);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check($sformatf("%s diff", tag), bus.diff, v.diff);
    check($sformatf("%s borrow", tag), bus.borrow, v.borrow);
    check($sformatf("%s ovf", tag), bus.ovf, v.ovf);
    check($sformatf("%s zero", tag), bus.zero, v.zero);
  endtask

  task automatic handshake(input string tag, input logic [15:0] held);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check($sformatf("%s out_valid drop", tag), bus.out_valid, 0);
    check($sformatf("%s back to idle", tag), bus.in_ready, 1);
    check($sformatf("%s diff held", tag), bus.diff, held);
  endtask

  initial begin
    vec_t v;
    bit   seen;

    vecs[0] = '{a: 16'h1234, b: 16'h0234, diff: 16'h1000, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, diff: 16'hFFFF, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[2] = '{a: 16'h8000, b: 16'h0001, diff: 16'h7FFF, borrow: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 16'h5A5A, b: 16'h5A5A, diff: 16'h0000, borrow: 1'b0, ovf: 1'b0, zero: 1'b1};
    vecs[4] = '{a: 16'h00F0, b: 16'h000F, diff: 16'h00E1, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[5] = '{a: 16'h7FFF, b: 16'hFFFF, diff: 16'h8000, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};
    vecs[6] = '{a: 16'hC3A0, b: 16'h41B7, diff: 16'h81E9, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[7] = '{a: 16'h0001, b: 16'h8000, diff: 16'h8001, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset held, then released: in_ready appears one edge after release.
    repeat (3) tick();
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst diff", bus.diff, 0);
    check("rst flags", {bus.borrow, bus.ovf, bus.zero}, 0);
    rst_n = 1'b1;
    check("release in_ready low", bus.in_ready, 0);
    tick();
    check("release in_ready high", bus.in_ready, 1);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(tag, vecs[i].a, vecs[i].b);
      wait_result(tag);
      check_result(tag, vecs[i]);
      handshake(tag, vecs[i].diff);
    end

    // Consumer stalls for 10 cycles while in_valid pulses with other operands.
    v = vecs[2];
    start_op("stall", v.a, v.b);
    wait_result("stall");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = 16'hFFFF;
      bus.b = 16'h0000;
      tick();
      check($sformatf("stall%0d out_valid", i), bus.out_valid, 1);
      check($sformatf("stall%0d in_ready", i), bus.in_ready, 0);
      check($sformatf("stall%0d diff", i), bus.diff, v.diff);
    end
    bus.in_valid = 1'b0;
    check_result("stall", v);
    handshake("stall", v.diff);

    // Async reset at idx=2 of FFFF-0001. Outputs clear before the next edge and no result appears.
    start_op("abort", 16'hFFFF, 16'h0001);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("abort diff", bus.diff, 0);
    check("abort borrow", bus.borrow, 0);
    check("abort ovf", bus.ovf, 0);
    check("abort in_ready", bus.in_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort no out_valid", seen, 0);

    v = '{a: 16'h0003, b: 16'h0005, diff: 16'hFFFE, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
    start_op("post", v.a, v.b);
    wait_result("post");
    check_result("post", v);
    handshake("post", v.diff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
